// File: rtl/ball_ctrl.sv
// Ball motion and game sequencer for pong.
// Owns the ball sprite position, advances it once per frame, bounces it off
// walls and paddles, detects misses, keeps score and runs serve/game-over.
module ball_ctrl #(
    parameter int X_POS_W      = 10,
    parameter int Y_POS_W      = 10,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int LPAD_X_R     = 24,
    parameter int RPAD_X_L     = 616,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_tick_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic [Y_POS_W-1:0] lpad_top_i,
    input  logic [Y_POS_W-1:0] lpad_bottom_i,
    input  logic [Y_POS_W-1:0] rpad_top_i,
    input  logic [Y_POS_W-1:0] rpad_bottom_i,
    output logic [X_POS_W-1:0] ball_x_o,
    output logic [Y_POS_W-1:0] ball_y_o,
    output logic [X_POS_W-1:0] ball_right_o,
    output logic [Y_POS_W-1:0] ball_bottom_o,
    output logic [3:0]         score_l_o,
    output logic [3:0]         score_r_o,
    output logic               point_o,
    output logic               game_over_o
);

    // Two guard bits so that x+SPEED+BALL_SIZE never wraps during comparisons.
    localparam int XW    = X_POS_W + 2;
    localparam int YW    = Y_POS_W + 2;
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES + 1) : 1;

    localparam logic [X_POS_W-1:0] X0 = X_POS_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [Y_POS_W-1:0] Y0 = Y_POS_W'((SCREEN_H - BALL_SIZE) / 2);

    localparam logic [XW-1:0] SPD_X   = XW'(SPEED);
    localparam logic [YW-1:0] SPD_Y   = YW'(SPEED);
    localparam logic [XW-1:0] SIZE_X  = XW'(BALL_SIZE);
    localparam logic [YW-1:0] SIZE_Y  = YW'(BALL_SIZE);
    localparam logic [XW-1:0] X_MAX   = XW'(SCREEN_W - BALL_SIZE);
    localparam logic [YW-1:0] Y_MAX   = YW'(SCREEN_H - BALL_SIZE);
    localparam logic [XW-1:0] LPAD_R  = XW'(LPAD_X_R);
    localparam logic [XW-1:0] RPAD_L  = XW'(RPAD_X_L);
    localparam logic [XW-1:0] LBOUNCE = XW'(LPAD_X_R + 1);
    localparam logic [XW-1:0] RBOUNCE = XW'(RPAD_X_L - BALL_SIZE - 1);
    localparam logic [3:0]    WIN     = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_MOVE,
        ST_SCORED,
        ST_OVER
    } state_t;

    state_t             state_reg, state_next;
    logic [X_POS_W-1:0] x_reg, x_next;
    logic [Y_POS_W-1:0] y_reg, y_next;
    logic [X_POS_W-1:0] right_reg, right_next;
    logic [Y_POS_W-1:0] bottom_reg, bottom_next;
    logic               dir_x_reg, dir_x_next;   // 1 = right
    logic               dir_y_reg, dir_y_next;   // 1 = down
    logic [3:0]         score_l_reg, score_l_next;
    logic [3:0]         score_r_reg, score_r_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               point_reg, point_next;
    logic               over_reg, over_next;

    // Candidate motion results, computed from pre-update values each cycle.
    logic [X_POS_W-1:0] mv_x;
    logic [Y_POS_W-1:0] mv_y;
    logic               mv_dx, mv_dy;
    logic               miss_l, miss_r;
    logic               advance;

    assign advance = frame_tick_i && !pause_i;

    // Per-axis motion: wall bounce on y, paddle bounce or miss on x.
    always_comb begin
        logic [XW-1:0] xe, nx;
        logic [YW-1:0] ye, ny;
        logic          ovl_l, ovl_r;
        xe     = XW'(x_reg);
        ye     = YW'(y_reg);
        mv_x   = x_reg;
        mv_y   = y_reg;
        mv_dx  = dir_x_reg;
        mv_dy  = dir_y_reg;
        miss_l = 1'b0;
        miss_r = 1'b0;
        nx     = '0;
        ny     = '0;
        ovl_l  = ((ye + SIZE_Y) > YW'(lpad_top_i)) && (ye < YW'(lpad_bottom_i));
        ovl_r  = ((ye + SIZE_Y) > YW'(rpad_top_i)) && (ye < YW'(rpad_bottom_i));

        if (!dir_y_reg) begin
            if (ye < SPD_Y) begin
                mv_y  = '0;
                mv_dy = 1'b1;
            end else begin
                ny   = ye - SPD_Y;
                mv_y = Y_POS_W'(ny);
            end
        end else begin
            ny = ye + SPD_Y;
            if (ny > Y_MAX) begin
                mv_y  = Y_POS_W'(Y_MAX);
                mv_dy = 1'b0;
            end else begin
                mv_y = Y_POS_W'(ny);
            end
        end

        if (!dir_x_reg) begin
            nx = xe - SPD_X;
            if ((xe > LPAD_R) && (nx <= LPAD_R) && ovl_l) begin
                mv_x  = X_POS_W'(LBOUNCE);
                mv_dx = 1'b1;
            end else if (xe < SPD_X) begin
                miss_l = 1'b1;
            end else begin
                mv_x = X_POS_W'(nx);
            end
        end else begin
            nx = xe + SPD_X;
            if (((xe + SIZE_X) < RPAD_L) && ((nx + SIZE_X) >= RPAD_L) && ovl_r) begin
                mv_x  = X_POS_W'(RBOUNCE);
                mv_dx = 1'b0;
            end else if (nx > X_MAX) begin
                miss_r = 1'b1;
            end else begin
                mv_x = X_POS_W'(nx);
            end
        end
    end

    // Game sequencer: next state, position, scores and pulse outputs.
    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        dir_x_next   = dir_x_reg;
        dir_y_next   = dir_y_reg;
        score_l_next = score_l_reg;
        score_r_next = score_r_reg;
        cnt_next     = cnt_reg;
        point_next   = 1'b0;
        over_next    = over_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_SERVE;
                    cnt_next   = '0;
                end
            end
            ST_SERVE: begin
                if (SERVE_FRAMES == 0) begin
                    state_next = ST_MOVE;
                end else if (advance) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_next == CNT_W'(SERVE_FRAMES)) begin
                        state_next = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                if (advance) begin
                    if (miss_l || miss_r) begin
                        // Recentre and serve toward the player who conceded.
                        x_next     = X0;
                        y_next     = Y0;
                        point_next = 1'b1;
                        state_next = ST_SCORED;
                        if (miss_l) begin
                            dir_x_next = 1'b0;
                            if (score_r_reg < WIN) score_r_next = score_r_reg + 1'b1;
                        end else begin
                            dir_x_next = 1'b1;
                            if (score_l_reg < WIN) score_l_next = score_l_reg + 1'b1;
                        end
                    end else begin
                        x_next     = mv_x;
                        y_next     = mv_y;
                        dir_x_next = mv_dx;
                        dir_y_next = mv_dy;
                    end
                end
            end
            ST_SCORED: begin
                cnt_next = '0;
                if ((score_l_reg == WIN) || (score_r_reg == WIN)) begin
                    state_next = ST_OVER;
                    over_next  = 1'b1;
                end else begin
                    state_next = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_i) begin
                    score_l_next = '0;
                    score_r_next = '0;
                    over_next    = 1'b0;
                    cnt_next     = '0;
                    state_next   = ST_SERVE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        right_next  = x_next + X_POS_W'(BALL_SIZE);
        bottom_next = y_next + Y_POS_W'(BALL_SIZE);
    end

    // State and output registers with asynchronous reset to the idle layout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            x_reg       <= X0;
            y_reg       <= Y0;
            right_reg   <= X0 + X_POS_W'(BALL_SIZE);
            bottom_reg  <= Y0 + Y_POS_W'(BALL_SIZE);
            dir_x_reg   <= 1'b1;
            dir_y_reg   <= 1'b1;
            score_l_reg <= '0;
            score_r_reg <= '0;
            cnt_reg     <= '0;
            point_reg   <= 1'b0;
            over_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            right_reg   <= right_next;
            bottom_reg  <= bottom_next;
            dir_x_reg   <= dir_x_next;
            dir_y_reg   <= dir_y_next;
            score_l_reg <= score_l_next;
            score_r_reg <= score_r_next;
            cnt_reg     <= cnt_next;
            point_reg   <= point_next;
            over_reg    <= over_next;
        end
    end

    assign ball_x_o      = x_reg;
    assign ball_y_o      = y_reg;
    assign ball_right_o  = right_reg;
    assign ball_bottom_o = bottom_reg;
    assign score_l_o     = score_l_reg;
    assign score_r_o     = score_r_reg;
    assign point_o       = point_reg;
    assign game_over_o   = over_reg;

endmodule

// File: tb/tb_ball_ctrl.sv
// Self-checking bench for ball_ctrl: directed game scenarios plus randomized
// play, all compared against a frame-level behavioural model of the game.
module tb_ball_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       frame_tick_i = 1'b0;
    logic       start_i = 1'b0;
    logic       pause_i = 1'b0;
    logic [9:0] lpad_top_i = '0, lpad_bottom_i = '0;
    logic [9:0] rpad_top_i = '0, rpad_bottom_i = '0;
    logic [9:0] ball_x_o, ball_y_o, ball_right_o, ball_bottom_o;
    logic [3:0] score_l_o, score_r_o;
    logic       point_o, game_over_o;

    int total = 0;
    int bad = 0;

    ball_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .frame_tick_i (frame_tick_i),
        .start_i      (start_i),
        .pause_i      (pause_i),
        .lpad_top_i   (lpad_top_i),
        .lpad_bottom_i(lpad_bottom_i),
        .rpad_top_i   (rpad_top_i),
        .rpad_bottom_i(rpad_bottom_i),
        .ball_x_o     (ball_x_o),
        .ball_y_o     (ball_y_o),
        .ball_right_o (ball_right_o),
        .ball_bottom_o(ball_bottom_o),
        .score_l_o    (score_l_o),
        .score_r_o    (score_r_o),
        .point_o      (point_o),
        .game_over_o  (game_over_o)
    );

    always #5 clk_i = ~clk_i;

    logic [49:0] dut_vec;
    assign dut_vec = {ball_x_o, ball_y_o, ball_right_o, ball_bottom_o,
                      score_l_o, score_r_o, point_o, game_over_o};

    // ---------------- behavioural game model ----------------
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;
    int m_phase, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_frames, m_pt, m_go;

    task automatic model_reset();
        m_phase = P_IDLE; m_x = 316; m_y = 236; m_vx = 2; m_vy = 2;
        m_sl = 0; m_sr = 0; m_frames = 0; m_pt = 0; m_go = 0;
    endtask

    // One clock edge of game behaviour, using the inputs currently applied.
    task automatic model_step();
        int  ny, nvy, nx, nvx;
        bit  hit_l, hit_r, go;
        go = frame_tick_i && !pause_i;
        case (m_phase)
            P_IDLE: if (start_i) begin m_phase = P_SERVE; m_frames = 0; end
            P_SERVE: if (go) begin
                m_frames++;
                if (m_frames == 60) m_phase = P_PLAY;
            end
            P_PLAY: if (go) begin
                nvy = m_vy;
                ny = m_y + m_vy;
                if (ny < 0) begin ny = 0; nvy = 2; end
                else if (ny > 472) begin ny = 472; nvy = -2; end
                hit_l = (m_y + 8 > int'(lpad_top_i)) && (m_y < int'(lpad_bottom_i));
                hit_r = (m_y + 8 > int'(rpad_top_i)) && (m_y < int'(rpad_bottom_i));
                nvx = m_vx;
                nx = m_x + m_vx;
                if (m_vx < 0 && m_x > 24 && nx <= 24 && hit_l) begin
                    nx = 25; nvx = 2;
                end else if (m_vx > 0 && m_x + 8 < 616 && nx + 8 >= 616 && hit_r) begin
                    nx = 607; nvx = -2;
                end
                if (nx < 0 || nx > 632) begin
                    if (nx < 0) begin m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_vx = -2; end
                    else        begin m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_vx = 2;  end
                    m_x = 316; m_y = 236; m_pt = 1; m_phase = P_POINT;
                end else begin
                    m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
                end
            end
            P_POINT: begin
                m_pt = 0; m_frames = 0;
                if (m_sl == 9 || m_sr == 9) begin m_phase = P_OVER; m_go = 1; end
                else m_phase = P_SERVE;
            end
            P_OVER: if (start_i) begin
                m_sl = 0; m_sr = 0; m_go = 0; m_frames = 0; m_phase = P_SERVE;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    function automatic logic [49:0] mdl_vec();
        return {10'(m_x), 10'(m_y), 10'(m_x + 8), 10'(m_y + 8),
                4'(m_sl), 4'(m_sr), 1'(m_pt), 1'(m_go)};
    endfunction

    // Apply inputs for one cycle, advance model at the edge, settle 1 time unit.
    task automatic cyc(input logic s, input logic p, input logic t);
        start_i = s; pause_i = p; frame_tick_i = t;
        @(posedge clk_i);
        model_step();
        #1;
        start_i = 1'b0; frame_tick_i = 1'b0;
    endtask

    task automatic set_pads(input int lt, input int lb, input int rt, input int rb);
        lpad_top_i = 10'(lt); lpad_bottom_i = 10'(lb);
        rpad_top_i = 10'(rt); rpad_bottom_i = 10'(rb);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        total++;
        if (dut_vec !== {10'd316, 10'd236, 10'd324, 10'd244, 4'd0, 4'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_values: got %h want 316/236/324/244 0/0/0/0", dut_vec);
        end
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (dut_vec !== mdl_vec()) begin
            bad++; $display("FAIL idle_ignores_tick: got %h want %h", dut_vec, mdl_vec());
        end
    endtask

    task automatic test_serve();
        set_pads(0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 60; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if (ball_x_o !== 10'd316 || ball_y_o !== 10'd236 || dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL serve_hold tick %0d: got %h want %h", i, dut_vec, mdl_vec());
            end
        end
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (ball_x_o !== 10'd318 || ball_y_o !== 10'd238 || dut_vec !== mdl_vec()) begin
            bad++; $display("FAIL serve_first_move: got x=%0d y=%0d want x=318 y=238", ball_x_o, ball_y_o);
        end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pause();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b1, 1'b0);
            total++;
            if (ball_x_o !== 10'd318 || ball_y_o !== 10'd238 || dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL pause_hold %0d: got x=%0d y=%0d want x=318 y=238", i, ball_x_o, ball_y_o);
            end
        end
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (ball_x_o !== 10'd320 || ball_y_o !== 10'd240 || dut_vec !== mdl_vec()) begin
            bad++; $display("FAIL pause_release: got x=%0d y=%0d want x=320 y=240", ball_x_o, ball_y_o);
        end
    endtask

    // Paddles out of the way: ball bounces off the bottom wall, then misses right.
    task automatic test_wall_and_miss();
        bit seen_bottom = 0, seen_point = 0;
        set_pads(0, 0, 0, 0);
        for (int i = 0; i < 400 && !seen_point; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            total++;
            if (dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL wall_miss step %0d: got %h want %h", i, dut_vec, mdl_vec());
            end
            if (ball_y_o == 10'd472) seen_bottom = 1;
            if (point_o) seen_point = 1;
            cyc(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (!seen_bottom || !seen_point || score_l_o !== 4'd1 || score_r_o !== 4'd0 ||
            ball_x_o !== 10'd316 || point_o !== 1'b0) begin
            bad++; $display("FAIL wall_miss_result: bottom=%0d point=%0d score=%0d/%0d x=%0d want 1 1 1/0 316",
                            seen_bottom, seen_point, score_l_o, score_r_o, ball_x_o);
        end
    endtask

    // Right paddle bounce, then a left miss; then left paddle bounce, right miss.
    task automatic test_paddles();
        bit seen607 = 0, seen25 = 0, seen27 = 0, done = 0;
        logic [9:0] prev_x;
        set_pads(0, 0, 0, 479);
        for (int i = 0; i < 1200 && !done; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            total++;
            if (dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL right_paddle step %0d: got %h want %h", i, dut_vec, mdl_vec());
            end
            if (ball_x_o == 10'd607) seen607 = 1;
            if (point_o) done = 1;
            cyc(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (!seen607 || !done || score_r_o !== 4'd1 || score_l_o !== 4'd1) begin
            bad++; $display("FAIL right_paddle_result: bounce=%0d point=%0d score=%0d/%0d want 1 1 1/1",
                            seen607, done, score_l_o, score_r_o);
        end
        set_pads(0, 479, 0, 0);
        done = 0;
        prev_x = ball_x_o;
        for (int i = 0; i < 1200 && !done; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            total++;
            if (dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL left_paddle step %0d: got %h want %h", i, dut_vec, mdl_vec());
            end
            if (ball_x_o == 10'd25) seen25 = 1;
            if (prev_x == 10'd25 && ball_x_o == 10'd27) seen27 = 1;
            prev_x = ball_x_o;
            if (point_o) done = 1;
            cyc(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (!seen25 || !seen27 || !done || score_l_o !== 4'd2 || score_r_o !== 4'd1) begin
            bad++; $display("FAIL left_paddle_result: x25=%0d x27=%0d point=%0d score=%0d/%0d want 1 1 1 2/1",
                            seen25, seen27, done, score_l_o, score_r_o);
        end
    endtask

    task automatic test_game_over();
        bit over = 0;
        set_pads(0, 0, 0, 0);
        for (int i = 0; i < 8000 && !over; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
            total++;
            if (dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL game_step %0d: got %h want %h", i, dut_vec, mdl_vec());
            end
            if (game_over_o) over = 1;
        end
        total++;
        if (!over || score_l_o !== 4'd9 || ball_x_o !== 10'd316 || ball_y_o !== 10'd236) begin
            bad++; $display("FAIL game_over_reached: over=%0d score_l=%0d x=%0d y=%0d want 1 9 316 236",
                            over, score_l_o, ball_x_o, ball_y_o);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            total++;
            if (game_over_o !== 1'b1 || score_l_o !== 4'd9 || ball_x_o !== 10'd316 || dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL over_ignores_tick %0d: got %h want %h", i, dut_vec, mdl_vec());
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
        total++;
        if (score_l_o !== 4'd0 || score_r_o !== 4'd0 || game_over_o !== 1'b0 || dut_vec !== mdl_vec()) begin
            bad++; $display("FAIL restart: score=%0d/%0d over=%0d want 0/0 0", score_l_o, score_r_o, game_over_o);
        end
    endtask

    // Reset asserted between edges while point_o is high clears everything at once.
    task automatic test_async_reset();
        bit hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (point_o) hit = 1;
            else cyc(1'b0, 1'b0, 1'b0);
        end
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        total++;
        if (!hit || dut_vec !== {10'd316, 10'd236, 10'd324, 10'd244, 4'd0, 4'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL async_reset: seen_point=%0d got %h want reset layout", hit, dut_vec);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        total++;
        if (dut_vec !== mdl_vec()) begin
            bad++; $display("FAIL after_reset_idle: got %h want %h", dut_vec, mdl_vec());
        end
    endtask

    task automatic test_random();
        logic p = 1'b0;
        int   top;
        for (int i = 0; i < 16000; i++) begin
            if ($urandom_range(0, 99) < 3) p = ~p;
            if ($urandom_range(0, 63) == 0) begin
                top = $urandom_range(0, 440);
                lpad_top_i = 10'(top); lpad_bottom_i = 10'(top + $urandom_range(10, 120));
                top = $urandom_range(0, 440);
                rpad_top_i = 10'(top); rpad_bottom_i = 10'(top + $urandom_range(10, 120));
            end
            cyc(($urandom_range(0, 199) == 0), p, ($urandom_range(0, 1) == 1));
            total++;
            if (dut_vec !== mdl_vec()) begin
                bad++; $display("FAIL random cycle %0d: got %h want %h", i, dut_vec, mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_pause();
        test_wall_and_miss();
        test_paddles();
        test_game_over();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
Per-frame ball motion and game sequencer for pong. It owns the ball sprite position. It advances the position once per video frame and bounces the ball off the top/bottom walls and both paddles. It detects misses, keeps the score and runs the serve/game-over sequence. Its position outputs drive the ball's sprite_display instance, and its paddle inputs come from the paddle sprite positions.

Parameters:
X_POS_W, 10, pixel x width (matches vga_pkg)
Y_POS_W, 10, pixel y width (matches vga_pkg)
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 8, ball edge length in pixels
SPEED, 2, pixels moved per frame on each axis (1..BALL_SIZE)
LPAD_X_R, 24, x of left paddle's right edge
RPAD_X_L, 616, x of right paddle's left edge
SERVE_FRAMES, 60, frames the ball is held at centre before moving
WIN_SCORE, 9, points that end the game (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
frame_tick_i  in  1  one-cycle pulse per frame (start of vblank)
start_i  in  1  level; starts play from IDLE or OVER
pause_i  in  1  level; freezes motion and serve countdown
lpad_top_i  in  Y_POS_W  left paddle top y
lpad_bottom_i  in  Y_POS_W  left paddle bottom y
rpad_top_i  in  Y_POS_W  right paddle top y
rpad_bottom_i  in  Y_POS_W  right paddle bottom y
ball_x_o  out  X_POS_W  ball left x
ball_y_o  out  Y_POS_W  ball top y
ball_right_o  out  X_POS_W  ball_x_o + BALL_SIZE
ball_bottom_o  out  Y_POS_W  ball_y_o + BALL_SIZE
score_l_o  out  4  left player score
score_r_o  out  4  right player score
point_o  out  1  one-cycle pulse when a point is awarded
game_over_o  out  1  high in OVER state

Behaviour:
- All outputs registered. Reset (async assert): state IDLE; ball at X0=(SCREEN_W-BALL_SIZE)/2=316, Y0=(SCREEN_H-BALL_SIZE)/2=236; dir_x=right, dir_y=down; scores 0; point_o=0; game_over_o=0; serve counter 0.
- right/bottom outputs are always consistent with x/y in the same cycle.
- IDLE: ball held at centre. start_i=1 moves to SERVE on the next clock and clears the serve counter.
- SERVE: ball at centre. Each frame_tick_i with pause_i=0 increments the counter. On the tick that makes it equal SERVE_FRAMES, go to MOVE. SERVE_FRAMES=0 moves to MOVE on the next clock without waiting for a tick.
- MOVE: the position updates only on frame_tick_i & !pause_i. The new value is visible the cycle after the tick.
- Vertical update:
  - Moving up with y < SPEED: y=0, dir_y flips to down.
  - Moving down with y+SPEED > SCREEN_H-BALL_SIZE: y=SCREEN_H-BALL_SIZE, dir_y flips to up.
  - Otherwise y ± SPEED.
- Horizontal update, left-moving, nx = x-SPEED:
  - If x > LPAD_X_R, nx <= LPAD_X_R, and the pre-move ball overlaps the paddle vertically (ball_bottom > lpad_top_i && ball_y < lpad_bottom_i): x=LPAD_X_R+1, dir_x flips to right.
  - Else if x < SPEED: miss; right player scores.
  - Else x=nx.
- Horizontal update, right-moving, nx = x+SPEED:
  - If x+BALL_SIZE < RPAD_X_L, nx+BALL_SIZE >= RPAD_X_L, and there is vertical overlap with the right paddle: x=RPAD_X_L-BALL_SIZE-1, dir_x flips to left.
  - Else if nx > SCREEN_W-BALL_SIZE: miss; left player scores.
  - Otherwise x=nx.
- Axis interaction: the x and y axes are evaluated independently from pre-update values within the same tick. A corner hit can flip both directions at once.
- On a miss, enter SCORED:
  - For one cycle, point_o=1 and the scorer's score increments.
  - Ball recentres. dir_x points toward the player who conceded. dir_y is kept.
  - If the new score == WIN_SCORE, go to OVER; else go to SERVE with the counter cleared.
- Scoring never wraps: scores are capped at WIN_SCORE.
- OVER: game_over_o=1, ball centred, scores held. start_i clears both scores, drops game_over_o and moves to SERVE.
- pause_i has no effect in IDLE, SCORED or OVER.
- frame_tick_i outside SERVE/MOVE is ignored.
- Async reset mid-frame or mid-point returns everything to the reset values immediately. No point_o is emitted.

Test Plan:
- Reset, then start_i, then 60 frame ticks: x=316, y=236 through 60 ticks. State goes SERVE→MOVE on the 60th. The next tick gives x=318, y=238.
- Ball moving up at y=1: the tick gives y=0 and dir_y=down. The next tick gives y=2. Repeat at the bottom with y=471: y=472, then 470.
- Left paddle top=100, bottom=160, ball x=26 moving left, y=120: the tick gives x=25 and dir_x=right. The next tick gives x=27.
- Same as above but paddle top=200: the ball passes the paddle and reaches x=0. The next tick gives point_o for 1 cycle, score_r_o=1, ball centred, dir_x=left, state SERVE.
- pause_i=1 for 10 ticks in MOVE: position unchanged. Release: motion resumes +SPEED per tick.
- score_l_o=8, left scores: score_l_o=9, game_over_o=1, ball centred. Ticks do nothing. start_i: scores 0/0, game_over_o=0, SERVE.
